// File: rtl/cost_rom_arbiter.sv
// Round-robin arbiter that shares a single 1-cycle Cost ROM among NUM_REQ evaluation engines.
// Supports burst locking up to MAX_BURST grants and returns tagged results after a fixed 2-cycle latency.
module cost_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NUM_REQ-1:0]     REQ,
    input  logic [NUM_REQ-1:0]     LOCK,
    input  logic [3*NUM_REQ-1:0]   W_IN,
    input  logic [3*NUM_REQ-1:0]   J_IN,
    output logic [NUM_REQ-1:0]     GNT,
    output logic [2:0]             W,
    output logic [2:0]             J,
    input  logic [6:0]             Cost,
    output logic [6:0]             RDATA,
    output logic [NUM_REQ-1:0]     RVALID,
    output logic                   BUSY
);

    localparam int         PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] CAP = 4'(MAX_BURST);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_owner;
    logic [3:0]           r_burst_cnt;
    logic                 r_v1;
    logic [PW-1:0]        r_tag1;
    logic [2:0]           r_w;
    logic [2:0]           r_j;
    logic [6:0]           r_rdata;
    logic [NUM_REQ-1:0]   r_rvalid;
    logic                 r_busy;

    logic                 w_hold;
    logic                 w_gnt_any;
    logic [PW-1:0]        w_winner;
    logic [NUM_REQ-1:0]   w_rot;
    logic [NUM_REQ-1:0]   w_gnt_vec;
    logic [PW-1:0]        w_ptr_next;
    logic [3:0]           w_cnt_next;
    logic [2:0]           w_w_sel;
    logic [2:0]           w_j_sel;

    // The owner keeps the ROM only while it still asserts LOCK and has burst budget left.
    assign w_hold     = (r_state == ST_LOCKED) && LOCK[r_owner] && (r_burst_cnt < CAP);
    assign w_rot      = NUM_REQ'({REQ, REQ} >> r_ptr);
    assign w_gnt_vec  = NUM_REQ'(1) << w_winner;
    assign w_ptr_next = (w_winner == PW'(NUM_REQ - 1)) ? '0 : w_winner + PW'(1);
    assign w_cnt_next = r_burst_cnt + 4'd1;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        logic [PW:0] v_sum;
        w_gnt_any = 1'b0;
        w_winner  = r_ptr;
        v_sum     = '0;
        if (w_hold) begin
            w_gnt_any = REQ[r_owner];
            w_winner  = r_owner;
        end else begin
            // Scan from the far end so the requester closest to r_ptr is assigned last and wins.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (w_rot[k]) begin
                    v_sum = {1'b0, r_ptr} + (PW+1)'(k);
                    if (v_sum >= (PW+1)'(NUM_REQ)) begin
                        v_sum = v_sum - (PW+1)'(NUM_REQ);
                    end
                    w_gnt_any = 1'b1;
                    w_winner  = v_sum[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        w_w_sel = '0;
        w_j_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == PW'(i)) begin
                w_w_sel = W_IN[3*i +: 3];
                w_j_sel = J_IN[3*i +: 3];
            end
        end
    end

    assign GNT = (RST_N && w_gnt_any) ? w_gnt_vec : '0;

    // NOTE: sequential state uses non-blocking assignments only; reset clears the pipeline valid
    // bits so an in-flight lookup never produces RVALID after reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_v1        <= 1'b0;
            r_tag1      <= '0;
            r_w         <= '0;
            r_j         <= '0;
            r_rdata     <= '0;
            r_rvalid    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_v1 <= w_gnt_any;
            if (w_gnt_any) begin
                r_w    <= w_w_sel;
                r_j    <= w_j_sel;
                r_tag1 <= w_winner;
                r_ptr  <= w_ptr_next;
            end

            r_rvalid <= r_v1 ? (NUM_REQ'(1) << r_tag1) : '0;
            if (r_v1) begin
                r_rdata <= Cost;
            end

            if (w_hold) begin
                // An owner bubble (REQ low, LOCK high) leaves the burst untouched.
                if (w_gnt_any) begin
                    r_burst_cnt <= w_cnt_next;
                    if (w_cnt_next == CAP) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            end else if (w_gnt_any && LOCK[w_winner] && (MAX_BURST > 1)) begin
                r_state     <= ST_LOCKED;
                r_busy      <= 1'b1;
                r_owner     <= w_winner;
                r_burst_cnt <= 4'd1;
            end else begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_burst_cnt <= '0;
            end
        end
    end

    assign W      = r_w;
    assign J      = r_j;
    assign RDATA  = r_rdata;
    assign RVALID = r_rvalid;
    assign BUSY   = r_busy;

endmodule

// File: tb/tb_cost_rom_arbiter.sv
// Self-checking bench for cost_rom_arbiter: directed scenarios plus randomized traffic,
// compared cycle by cycle against a behavioural arbitration/latency model.
module tb_cost_rom_arbiter;

    localparam int N   = 4;
    localparam int CAP = 8;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [N-1:0]      REQ = '0;
    logic [N-1:0]      LOCK = '0;
    logic [3*N-1:0]    W_IN = '0;
    logic [3*N-1:0]    J_IN = '0;
    logic [N-1:0]      GNT;
    logic [2:0]        W;
    logic [2:0]        J;
    logic [6:0]        Cost;
    logic [6:0]        RDATA;
    logic [N-1:0]      RVALID;
    logic              BUSY;

    cost_rom_arbiter #(.NUM_REQ(N), .MAX_BURST(CAP)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .REQ    (REQ),
        .LOCK   (LOCK),
        .W_IN   (W_IN),
        .J_IN   (J_IN),
        .GNT    (GNT),
        .W      (W),
        .J      (J),
        .Cost   (Cost),
        .RDATA  (RDATA),
        .RVALID (RVALID),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    // Cost ROM: Cost = W*8 + J for whatever address the arbiter presents.
    assign Cost = {1'b0, W, J};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state.
    bit m_known  = 0;
    int m_ptr    = 0;
    bit m_locked = 0;
    int m_owner  = 0;
    int m_cnt    = 0;
    int m_w      = 0;
    int m_j      = 0;
    bit m_s1v    = 0;
    int m_s1tag  = 0;
    int m_s1cost = 0;
    int m_rv     = 0;
    int m_rdata  = 0;

    logic [3*N-1:0] pat_w;
    logic [3*N-1:0] pat_j;

    // One clock cycle: apply inputs after the falling edge, check, then advance the model.
    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lock, input logic rst,
                         input logic [3*N-1:0] w_in, input logic [3*N-1:0] j_in);
        int  win;
        bit  hold;
        int  exp_gnt;
        @(negedge CLK);
        RST_N = rst;
        REQ   = req;
        LOCK  = lock;
        W_IN  = w_in;
        J_IN  = j_in;
        #1;
        win  = -1;
        hold = 0;
        if (rst) begin
            if (m_locked && lock[m_owner] && m_cnt < CAP) begin
                hold = 1;
                if (req[m_owner]) win = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (win < 0 && req[idx]) win = idx;
                end
            end
        end
        exp_gnt = (win >= 0) ? (1 << win) : 0;
        check("gnt", 32'(GNT), 32'(exp_gnt));
        if (m_known) begin
            check("busy", 32'(BUSY), 32'(m_locked));
            check("rvalid", 32'(RVALID), 32'(m_rv));
            if (m_rv != 0) check("rdata", 32'(RDATA), 32'(m_rdata));
            check("w", 32'(W), 32'(m_w));
            check("j", 32'(J), 32'(m_j));
        end
        if (!rst) begin
            m_known  = 1;
            m_ptr    = 0;
            m_locked = 0;
            m_owner  = 0;
            m_cnt    = 0;
            m_w      = 0;
            m_j      = 0;
            m_s1v    = 0;
            m_rv     = 0;
        end else begin
            m_rv = m_s1v ? (1 << m_s1tag) : 0;
            if (m_s1v) m_rdata = m_s1cost;
            m_s1v = (win >= 0);
            if (win >= 0) begin
                m_w      = int'(w_in[3*win +: 3]);
                m_j      = int'(j_in[3*win +: 3]);
                m_s1tag  = win;
                m_s1cost = m_w * 8 + m_j;
                m_ptr    = (win + 1) % N;
            end
            if (hold) begin
                if (win >= 0) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == CAP) m_locked = 0;
                end
            end else if (win >= 0 && lock[win] && CAP > 1) begin
                m_locked = 1;
                m_owner  = win;
                m_cnt    = 1;
            end else begin
                m_locked = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, 1'b1, pat_w, pat_j);
    endtask

    int burst_grants;

    initial begin
        for (int i = 0; i < N; i++) begin
            pat_w[3*i +: 3] = 3'(i);
            pat_j[3*i +: 3] = 3'(7 - i);
        end

        // Reset with every requester asking: no grants, outputs cleared.
        drive(4'b1111, '0, 1'b0, pat_w, pat_j);
        drive(4'b1111, '0, 1'b0, pat_w, pat_j);

        // Round-robin rotation with the W=i, J=7-i address pattern.
        for (int c = 0; c < 9; c++) drive(4'b1111, '0, 1'b1, pat_w, pat_j);
        idle(3);

        // Burst cap: requester 2 locks while requester 0 keeps asking.
        burst_grants = 0;
        drive(4'b0100, 4'b0100, 1'b1, pat_w, pat_j);
        if (GNT == 4'b0100) burst_grants++;
        for (int c = 0; c < CAP; c++) begin
            drive(4'b0101, 4'b0100, 1'b1, pat_w, pat_j);
            if (GNT == 4'b0100) burst_grants++;
        end
        check("burst_len", 32'(burst_grants), 32'(CAP));
        check("after_cap_gnt", 32'(GNT), 32'b0001);
        idle(3);

        // Early release with owner bubbles; requester 3 wins in the release cycle.
        drive(4'b0010, 4'b0010, 1'b1, pat_w, pat_j);
        drive(4'b0000, 4'b0010, 1'b1, pat_w, pat_j);
        drive(4'b0000, 4'b0010, 1'b1, pat_w, pat_j);
        drive(4'b1010, 4'b0010, 1'b1, pat_w, pat_j);
        drive(4'b1010, 4'b0010, 1'b1, pat_w, pat_j);
        drive(4'b1010, 4'b0000, 1'b1, pat_w, pat_j);
        check("release_gnt", 32'(GNT), 32'b1000);
        idle(3);

        // Reset the cycle after a grant: lookup dropped, pointer back at 0.
        drive(4'b0100, '0, 1'b1, pat_w, pat_j);
        drive('0, '0, 1'b0, pat_w, pat_j);
        idle(3);
        drive(4'b1111, '0, 1'b1, pat_w, pat_j);
        check("post_reset_gnt", 32'(GNT), 32'b0001);
        idle(3);

        // Sparse single-requester pulses.
        for (int p = 0; p < 4; p++) begin
            drive(4'b1000, '0, 1'b1, pat_w, pat_j);
            idle(2);
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 500; c++) begin
            logic [N-1:0]   r_req;
            logic [N-1:0]   r_lock;
            logic           r_rst;
            logic [3*N-1:0] r_w;
            logic [3*N-1:0] r_j;
            r_req  = N'($urandom);
            r_lock = N'($urandom) & N'($urandom | $urandom);
            r_rst  = ($urandom_range(0, 60) != 0);
            r_w    = (3*N)'($urandom);
            r_j    = (3*N)'($urandom);
            drive(r_req, r_lock, r_rst, r_w, r_j);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cost_rom_arbiter.md
Name: cost_rom_arbiter

Overview:
- Shares the single 1-cycle Cost ROM (W/J address in, 7-bit Cost out) among NUM_REQ job-assignment evaluation engines so they can search permutation sub-ranges in parallel.
- Arbitration is round-robin. A requester may lock the ROM for a burst (one permutation = 8 worker lookups), capped at MAX_BURST grants.
- Each accepted lookup returns Cost to its owner, tagged by a one-hot RVALID, with a fixed latency.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 8, maximum consecutive grants under LOCK before forced re-arbitration (1..15).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST_N  input  1  synchronous active-low reset.
- REQ  input  NUM_REQ  per-requester lookup request; held until granted.
- LOCK  input  NUM_REQ  per-requester burst-hold request; sampled with REQ.
- W_IN  input  3*NUM_REQ  worker index of requester i at bits [3i+2:3i].
- J_IN  input  3*NUM_REQ  job index of requester i at bits [3i+2:3i].
- GNT  output  NUM_REQ  one-hot, combinational; GNT[i]=1 means requester i's W_IN/J_IN is accepted this cycle.
- W  output  3  registered worker address to Cost ROM.
- J  output  3  registered job address to Cost ROM.
- Cost  input  7  ROM data, valid in the cycle W/J are presented.
- RDATA  output  7  registered returned cost, shared by all requesters.
- RVALID  output  NUM_REQ  one-hot registered; RVALID[i]=1 means RDATA belongs to requester i.
- BUSY  output  1  high while in LOCKED state.

Behaviour:
- Reset: RST_N low at a rising edge resets state to IDLE, ptr=0, owner=0, burst_cnt=0. It also clears W=0, J=0, RDATA=0, RVALID=0, BUSY=0 and the internal lookup pipeline valid bits. GNT is forced to 0 while RST_N is low.
- A reset mid-burst or mid-lookup drops all in-flight lookups; no RVALID appears for them.
- Round-robin: the winner is the first i with REQ[i]=1, scanning ptr, ptr+1, ... modulo NUM_REQ. On every grant, ptr <= (winner+1) mod NUM_REQ.
- At most one GNT bit is high per cycle. GNT[i] is never high when REQ[i] is low.
- Pipeline (latency 2 cycles from grant to RVALID):
  - Cycle t: GNT[i]=1.
  - Edge end of t: W<=W_IN[i], J<=J_IN[i], and stage-1 tag <= i with valid=1.
  - Cycle t+1: ROM drives Cost.
  - Edge end of t+1: RDATA<=Cost, RVALID<=onehot(tag).
  - Cycle t+2: RVALID[i]=1.
- Throughput is one lookup per cycle with back-to-back grants; there is no backpressure on RVALID.
- With no grant in a cycle, W/J hold their values and the stage-1 valid bit is 0, so RVALID=0 two cycles later.
- FSM IDLE:
  - Any REQ: grant the RR winner.
  - If LOCK[winner]=1 and MAX_BURST>1: go to LOCKED with owner=winner, burst_cnt=1.
  - Otherwise stay in IDLE.
- FSM LOCKED:
  - Hold condition: LOCK[owner]=1 and burst_cnt<MAX_BURST. Only the owner can be granted, with GNT[owner]=REQ[owner]; other REQs wait.
  - On each grant, burst_cnt++. If burst_cnt reaches MAX_BURST on that grant, go to IDLE next cycle.
  - Owner REQ low with LOCK high: no grant, stay LOCKED, burst_cnt unchanged (bubble).
  - LOCK[owner] low in a LOCKED cycle: the cycle is evaluated as IDLE (RR among all REQ using the current ptr) and the state goes to IDLE, or to LOCKED with the new winner if that winner asserts LOCK.
- BUSY = (state==LOCKED).
- Width rules:
  - burst_cnt is 4 bits and never exceeds MAX_BURST.
  - ptr and owner are clog2(NUM_REQ) bits.
  - Wrap: ptr past NUM_REQ-1 returns to 0.
- Simultaneous events:
  - Owner dropping LOCK and another requester raising REQ in the same cycle: that requester may win in that cycle.
  - A burst hitting its cap while others request: the next cycle grants the RR winner, which excludes the previous owner unless it is the only requester.

Test Plan:
- Reset/idle: hold RST_N=0 for 2 cycles with REQ=4'b1111. Require GNT=0, RVALID=0, W=J=0. Release, then check the first GNT=4'b0001.
- Round-robin: REQ=4'b1111, LOCK=0 held for 8 cycles. Require GNT=0001,0010,0100,1000,0001,... Feed a ROM model Cost=W*8+J with requester i using W=i, J=7-i; RVALID[i] must appear 2 cycles after GNT[i] with RDATA=8i+7-i.
- Burst cap: requester 2 holds REQ=1, LOCK=1 while REQ[0]=1. Require exactly 8 consecutive GNT=0100 with BUSY=1, then GNT=0001 on the 9th cycle and BUSY=0.
- Early release and bubble: requester 1 locks, drops REQ for 2 cycles (no GNT, BUSY stays 1), then drops LOCK after 3 grants while REQ[3]=1. Require GNT=1000 in that same cycle.
- Reset mid-flight: assert RST_N=0 in the cycle after a grant. Require no RVALID ever for that lookup and ptr restarting at 0.
- Sparse traffic: single REQ[3] pulses every 3 cycles. Require a grant in the same cycle each time and RVALID[3] exactly 2 cycles later, with RVALID=0 otherwise.
